sgmii_autoneg: RTL and testbench

Parametrised single-clock Clause 37 / SGMII auto-negotiation engine that drives the config ordered-set transmitter and consumes decoded receive config words. It sits between the 8b/10b code-group layer and the GMII side of the SGMII TBI path, replacing fixed-behaviour negotiation with configurable link timer, match count and 1000BASE-X/SGMII mode. It reports partner ability, resolved speed/duplex and `autoneg_complete` to the MAC.

---
 rtl/sgmii_autoneg_if.sv | 34 +++
 rtl/sgmii_autoneg.sv | 243 ++++++++++++++++++++++++
 tb/tb_sgmii_autoneg.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sgmii_autoneg_if.sv
// rtl/sgmii_autoneg_if.sv - config ordered-set receive/transmit bundle for sgmii_autoneg
//
// Purpose: groups the code-group-layer side of the auto-negotiation engine.
// Ports (members):
//   rx_cfg_valid  one pulse per received /C/ ordered set
//   rx_cfg_word   received config word, valid with rx_cfg_valid
//   rx_idle       one pulse per received /I/ ordered set
//   tx_cfg_en     1 = transmit /C/ carrying tx_cfg_word
//   tx_cfg_word   config word to transmit
// master = code-group layer, slave = negotiation engine.

interface sgmii_autoneg_if;
    logic        rx_cfg_valid;
    logic [15:0] rx_cfg_word;
    logic        rx_idle;
    logic        tx_cfg_en;
    logic [15:0] tx_cfg_word;

    modport master (
        output rx_cfg_valid,
        output rx_cfg_word,
        output rx_idle,
        input  tx_cfg_en,
        input  tx_cfg_word
    );

    modport slave (
        input  rx_cfg_valid,
        input  rx_cfg_word,
        input  rx_idle,
        output tx_cfg_en,
        output tx_cfg_word
    );
endinterface

// File: rtl/sgmii_autoneg.sv
// rtl/sgmii_autoneg.sv - Clause 37 / SGMII auto-negotiation engine
//
// Purpose: drives the /C/ ordered-set transmitter, matches received config
// words, and reports partner ability, speed and duplex to the MAC.
// Ports:
//   clk_125mhz        sole clock
//   rst_n             asynchronous active-low reset
//   an_enable         1 = negotiate, 0 = bypass straight to link up
//   restart_an        single-cycle restart request
//   rx_sync           code-group sync acquired
//   an_if             rx config/idle events in, tx config word out
//   autoneg_complete  link up, negotiation resolved
//   config_reg        captured partner word
//   link_speed        00 = 10M, 01 = 100M, 10 = 1000M
//   link_duplex       1 = full duplex

module sgmii_autoneg #(
    parameter int unsigned LINK_TIMER = 200000,
    parameter int unsigned MATCH_CNT  = 3,
    parameter int          MODE       = 1,
    parameter logic [15:0] TX_CONFIG  = 16'h0001
) (
    input  logic                  clk_125mhz,
    input  logic                  rst_n,
    input  logic                  an_enable,
    input  logic                  restart_an,
    input  logic                  rx_sync,
    sgmii_autoneg_if.slave        an_if,
    output logic                  autoneg_complete,
    output logic [15:0]           config_reg,
    output logic [1:0]            link_speed,
    output logic                  link_duplex
);

    localparam int TW = $clog2(LINK_TIMER + 1);
    localparam int CW = $clog2(MATCH_CNT + 1);

    localparam logic [TW-1:0] TIMER_LAST = TW'(LINK_TIMER - 1);
    localparam logic [CW-1:0] MATCH_MAX  = CW'(MATCH_CNT);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [15:0]   ACK_BIT    = 16'h4000;
    localparam logic [15:0]   TX_ABILITY = TX_CONFIG & ~ACK_BIT;
    localparam logic [15:0]   TX_ACK     = TX_CONFIG | ACK_BIT;

    typedef enum logic [2:0] {
        AN_RESTART,
        ABILITY_DETECT,
        ACK_DETECT,
        COMPLETE_ACK,
        IDLE_DETECT,
        LINK_OK
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [TW-1:0]  timer;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_nxt;
    logic [CW-1:0]  cnt_plus;
    logic [15:0]    ability;
    logic [15:0]    ability_nxt;
    logic           restart;
    logic           bypass;
    logic           entry;
    logic           timer_done;
    logic           zero_word;
    logic           same_word;
    logic           tx_en_nxt;
    logic [15:0]    tx_word_nxt;

    function automatic logic [1:0] speed_of(input logic [15:0] w);
        if (MODE == 0) begin
            return 2'b10;
        end
        // 2'b11 is reserved in SGMII; treat it as gigabit.
        return (w[11:10] == 2'b11) ? 2'b10 : w[11:10];
    endfunction

    function automatic logic duplex_of(input logic [15:0] w);
        return (MODE == 0) ? w[5] : w[12];
    endfunction

    // timer_done is true on the edge that completes LINK_TIMER cycles in the state;
    // the timer then parks there so IDLE_DETECT can still see it expired.
    assign timer_done = (timer == TIMER_LAST);
    assign zero_word  = an_if.rx_cfg_valid && (an_if.rx_cfg_word == 16'h0000);
    assign same_word  = ((an_if.rx_cfg_word & ~ACK_BIT) == (ability & ~ACK_BIT));
    assign cnt_plus   = (cnt == MATCH_MAX) ? cnt : cnt + 1'b1;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        ability_nxt = ability;
        restart     = 1'b0;
        bypass      = 1'b0;

        if (!rx_sync || restart_an) begin
            state_nxt = AN_RESTART;
            restart   = 1'b1;
        end else if (!an_enable && state != LINK_OK) begin
            state_nxt = LINK_OK;
            bypass    = 1'b1;
        end else if (zero_word && state != AN_RESTART) begin
            state_nxt = AN_RESTART;
            restart   = 1'b1;
        end else begin
            case (state)
                AN_RESTART: begin
                    if (timer_done) begin
                        state_nxt = ABILITY_DETECT;
                    end
                end

                ABILITY_DETECT: begin
                    if (an_if.rx_cfg_valid) begin
                        // ability doubles as the candidate word being matched
                        ability_nxt = an_if.rx_cfg_word;
                        cnt_nxt     = (cnt != '0 && same_word) ? cnt_plus : CNT_ONE;
                        if (cnt_nxt == MATCH_MAX) begin
                            state_nxt = ACK_DETECT;
                        end
                    end
                end

                ACK_DETECT: begin
                    if (an_if.rx_cfg_valid) begin
                        if (!same_word) begin
                            state_nxt = AN_RESTART;
                        end else if (an_if.rx_cfg_word[14]) begin
                            ability_nxt = an_if.rx_cfg_word;
                            cnt_nxt     = cnt_plus;
                            if (cnt_plus == MATCH_MAX) begin
                                state_nxt = COMPLETE_ACK;
                            end
                        end
                    end
                end

                COMPLETE_ACK: begin
                    if (an_if.rx_cfg_valid && !same_word) begin
                        state_nxt = AN_RESTART;
                    end else begin
                        if (an_if.rx_cfg_valid) begin
                            ability_nxt = an_if.rx_cfg_word;
                        end
                        if (timer_done) begin
                            state_nxt = IDLE_DETECT;
                        end
                    end
                end

                IDLE_DETECT: begin
                    // a config word in the same cycle as an idle wins
                    if (an_if.rx_cfg_valid) begin
                        cnt_nxt = '0;
                    end else if (an_if.rx_idle) begin
                        cnt_nxt = cnt_plus;
                    end
                    if (timer_done && cnt_nxt == MATCH_MAX) begin
                        state_nxt = LINK_OK;
                    end
                end

                LINK_OK: begin
                end

                default: begin
                    state_nxt = AN_RESTART;
                end
            endcase
        end
    end

    // restart requests re-enter AN_RESTART even when already there
    assign entry = restart || (state_nxt != state);

    always_comb begin
        tx_en_nxt   = 1'b0;
        tx_word_nxt = 16'h0000;
        case (state_nxt)
            AN_RESTART: begin
                tx_en_nxt   = 1'b1;
                tx_word_nxt = 16'h0000;
            end
            ABILITY_DETECT: begin
                tx_en_nxt   = 1'b1;
                tx_word_nxt = TX_ABILITY;
            end
            ACK_DETECT, COMPLETE_ACK: begin
                tx_en_nxt   = 1'b1;
                tx_word_nxt = TX_ACK;
            end
            default: begin
                tx_en_nxt   = 1'b0;
                tx_word_nxt = 16'h0000;
            end
        endcase
    end

    always_ff @(posedge clk_125mhz or negedge rst_n) begin
        if (!rst_n) begin
            state             <= AN_RESTART;
            timer             <= '0;
            cnt               <= '0;
            ability           <= 16'h0000;
            an_if.tx_cfg_en   <= 1'b1;
            an_if.tx_cfg_word <= 16'h0000;
            autoneg_complete  <= 1'b0;
            config_reg        <= 16'h0000;
            link_speed        <= 2'b00;
            link_duplex       <= 1'b0;
        end else begin
            state   <= state_nxt;
            ability <= ability_nxt;

            if (entry) begin
                timer <= '0;
                cnt   <= '0;
            end else begin
                if (!timer_done) begin
                    timer <= timer + 1'b1;
                end
                cnt <= cnt_nxt;
            end

            an_if.tx_cfg_en   <= tx_en_nxt;
            an_if.tx_cfg_word <= tx_word_nxt;
            autoneg_complete  <= (state_nxt == LINK_OK);

            // status is loaded once on entry to LINK_OK and held afterwards
            if (bypass) begin
                config_reg  <= 16'h0000;
                link_speed  <= 2'b10;
                link_duplex <= 1'b1;
            end else if (state_nxt == LINK_OK && state != LINK_OK) begin
                config_reg  <= ability;
                link_speed  <= speed_of(ability);
                link_duplex <= duplex_of(ability);
            end
        end
    end

endmodule

// File: tb/tb_sgmii_autoneg.sv
// tb/tb_sgmii_autoneg.sv - self-checking bench for sgmii_autoneg (SGMII and 1000BASE-X instances)

module tb_sgmii_autoneg;
    localparam int LT = 16;
    localparam int MC = 3;

    localparam int P_RST  = 0;
    localparam int P_ABL  = 1;
    localparam int P_ACK  = 2;
    localparam int P_CACK = 3;
    localparam int P_IDL  = 4;
    localparam int P_OK   = 5;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        an_enable  = 1'b1;
    logic        restart_an = 1'b0;
    logic        rx_sync    = 1'b1;
    logic        rx_valid   = 1'b0;
    logic [15:0] rx_word    = 16'h0000;
    logic        rx_idle    = 1'b0;

    always #4 clk = ~clk;

    sgmii_autoneg_if if1 ();
    sgmii_autoneg_if if0 ();

    assign if1.rx_cfg_valid = rx_valid;
    assign if1.rx_cfg_word  = rx_word;
    assign if1.rx_idle      = rx_idle;
    assign if0.rx_cfg_valid = rx_valid;
    assign if0.rx_cfg_word  = rx_word;
    assign if0.rx_idle      = rx_idle;

    logic        cmp1, cmp0;
    logic [15:0] creg1, creg0;
    logic [1:0]  spd1, spd0;
    logic        dup1, dup0;

    sgmii_autoneg #(.LINK_TIMER(LT), .MATCH_CNT(MC), .MODE(1), .TX_CONFIG(16'h0001)) dut1 (
        .clk_125mhz(clk), .rst_n(rst_n), .an_enable(an_enable), .restart_an(restart_an),
        .rx_sync(rx_sync), .an_if(if1), .autoneg_complete(cmp1), .config_reg(creg1),
        .link_speed(spd1), .link_duplex(dup1)
    );

    sgmii_autoneg #(.LINK_TIMER(LT), .MATCH_CNT(MC), .MODE(0), .TX_CONFIG(16'h0001)) dut0 (
        .clk_125mhz(clk), .rst_n(rst_n), .an_enable(an_enable), .restart_an(restart_an),
        .rx_sync(rx_sync), .an_if(if0), .autoneg_complete(cmp0), .config_reg(creg0),
        .link_speed(spd0), .link_duplex(dup0)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: phase number, cycles spent in the phase, run length of
    // qualifying events, and the partner word as last accepted.
    int ph = P_RST, cyc = 0, run = 0, abil = 0;
    int m_cfg = 0, m_sp1 = 0, m_dp1 = 0, m_sp0 = 0, m_dp0 = 0;
    bit m_cmp = 1'b0;

    function automatic int ign14(input int w);
        return w & 'hBFFF;
    endfunction

    task automatic model_step();
        int  nph;
        bit  fresh;
        bit  byp;
        bit  tdone;
        int  w;
        if (!rst_n) begin
            ph = P_RST; cyc = 0; run = 0; abil = 0; m_cmp = 1'b0;
            m_cfg = 0; m_sp1 = 0; m_dp1 = 0; m_sp0 = 0; m_dp0 = 0;
        end else begin
            w     = int'(rx_word);
            nph   = ph;
            fresh = 1'b0;
            byp   = 1'b0;
            tdone = (cyc + 1 >= LT);
            if (!rx_sync || restart_an) begin
                nph = P_RST; fresh = 1'b1;
            end else if (!an_enable && ph != P_OK) begin
                nph = P_OK; byp = 1'b1;
            end else if (rx_valid && w == 0 && ph != P_RST) begin
                nph = P_RST; fresh = 1'b1;
            end else begin
                case (ph)
                    P_RST: if (tdone) nph = P_ABL;
                    P_ABL: if (rx_valid) begin
                        run  = (run > 0 && ign14(w) == ign14(abil)) ? run + 1 : 1;
                        abil = w;
                        if (run >= MC) nph = P_ACK;
                    end
                    P_ACK: if (rx_valid) begin
                        if (ign14(w) != ign14(abil)) nph = P_RST;
                        else if ((w & 'h4000) != 0) begin
                            abil = w;
                            run  = run + 1;
                            if (run >= MC) nph = P_CACK;
                        end
                    end
                    P_CACK: begin
                        if (rx_valid && ign14(w) != ign14(abil)) nph = P_RST;
                        else begin
                            if (rx_valid) abil = w;
                            if (tdone) nph = P_IDL;
                        end
                    end
                    P_IDL: begin
                        if (rx_valid) run = 0;
                        else if (rx_idle) run = run + 1;
                        if (tdone && run >= MC) nph = P_OK;
                    end
                    default: ;
                endcase
            end
            if (nph == P_OK && ph != P_OK) begin
                if (byp) begin
                    m_cfg = 0; m_sp1 = 2; m_dp1 = 1; m_sp0 = 2; m_dp0 = 1;
                end else begin
                    m_cfg = abil;
                    m_sp1 = (((abil >> 10) & 3) == 3) ? 2 : ((abil >> 10) & 3);
                    m_dp1 = (abil >> 12) & 1;
                    m_sp0 = 2;
                    m_dp0 = (abil >> 5) & 1;
                end
            end
            if (fresh || nph != ph) begin
                cyc = 0; run = 0;
            end else begin
                cyc = cyc + 1;
            end
            ph    = nph;
            m_cmp = (ph == P_OK);
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    function automatic int exp_en();
        return (ph <= P_CACK) ? 1 : 0;
    endfunction

    function automatic int exp_word();
        return (ph == P_RST) ? 0 : ((ph == P_ABL) ? 'h0001 : 'h4001);
    endfunction

    initial forever begin
        @(negedge clk);
        chk("dut1 tx_cfg_en", int'(if1.tx_cfg_en), exp_en());
        chk("dut0 tx_cfg_en", int'(if0.tx_cfg_en), exp_en());
        if (exp_en() == 1) begin
            chk("dut1 tx_cfg_word", int'(if1.tx_cfg_word), exp_word());
            chk("dut0 tx_cfg_word", int'(if0.tx_cfg_word), exp_word());
        end
        chk("dut1 autoneg_complete", int'(cmp1), int'(m_cmp));
        chk("dut0 autoneg_complete", int'(cmp0), int'(m_cmp));
        if (m_cmp) begin
            chk("dut1 config_reg", int'(creg1), m_cfg);
            chk("dut0 config_reg", int'(creg0), m_cfg);
            chk("dut1 link_speed", int'(spd1), m_sp1);
            chk("dut1 link_duplex", int'(dup1), m_dp1);
            chk("dut0 link_speed", int'(spd0), m_sp0);
            chk("dut0 link_duplex", int'(dup0), m_dp0);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cfg(input logic [15:0] w);
        rx_valid = 1'b1;
        rx_word  = w;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_word  = 16'h0000;
        @(negedge clk);
    endtask

    task automatic idle_ev();
        rx_idle = 1'b1;
        @(negedge clk);
        rx_idle = 1'b0;
        @(negedge clk);
    endtask

    task automatic negotiate(input logic [15:0] w);
        cycles(LT + 2);
        repeat (MC) cfg(w & 16'hBFFF);
        repeat (MC) cfg(w | 16'h4000);
        cycles(LT + 2);
        repeat (MC) idle_ev();
        cycles(LT + 2);
    endtask

    task automatic check_restarted(input string tag);
        #1;
        chk({tag, " complete"}, int'(cmp1), 0);
        chk({tag, " tx_cfg_en"}, int'(if1.tx_cfg_en), 1);
        chk({tag, " tx_cfg_word"}, int'(if1.tx_cfg_word), 0);
    endtask

    initial begin
        // reset values
        cycles(3);
        #1;
        chk("reset tx_cfg_en", int'(if1.tx_cfg_en), 1);
        chk("reset tx_cfg_word", int'(if1.tx_cfg_word), 0);
        chk("reset complete", int'(cmp1), 0);
        chk("reset config_reg", int'(creg1), 0);
        chk("reset link_speed", int'(spd1), 0);
        chk("reset link_duplex", int'(dup1), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // AN_RESTART lasts exactly LT edges after release
        for (int k = 1; k <= LT; k++) begin
            @(negedge clk);
            if (k == LT - 1) begin
                #1;
                chk("restart hold word", int'(if1.tx_cfg_word), 0);
                chk("restart hold en", int'(if1.tx_cfg_en), 1);
            end else if (k == LT) begin
                #1;
                chk("ability tx word", int'(if1.tx_cfg_word), 'h0001);
            end
        end

        // full negotiation with exact timing
        repeat (MC) cfg(16'h9801);
        #1 chk("ack tx word", int'(if1.tx_cfg_word), 'h4001);
        repeat (MC) cfg(16'hD801);
        cycles(LT - 2);
        #1 chk("complete_ack still tx", int'(if1.tx_cfg_en), 1);
        cycles(1);
        #1 chk("idle_detect tx off", int'(if1.tx_cfg_en), 0);
        repeat (MC) idle_ev();
        cycles(LT - 7);
        #1 chk("idle timer not expired", int'(cmp1), 0);
        cycles(1);
        #1;
        chk("link complete", int'(cmp1), 1);
        chk("link config_reg", int'(creg1), 'hD801);
        chk("link speed", int'(spd1), 2);
        chk("link duplex", int'(dup1), 1);

        // zero config word in LINK_OK
        cfg(16'h0000);
        check_restarted("zero word");
        negotiate(16'h9801);
        #1 chk("renegotiate 1", int'(cmp1), 1);

        // restart_an pulse
        restart_an = 1'b1;
        @(negedge clk);
        restart_an = 1'b0;
        @(negedge clk);
        check_restarted("restart_an");
        negotiate(16'h9801);
        #1 chk("renegotiate 2", int'(cmp1), 1);

        // rx_sync drop
        rx_sync = 1'b0;
        @(negedge clk);
        rx_sync = 1'b1;
        @(negedge clk);
        check_restarted("rx_sync drop");

        // match interruption
        cycles(LT + 2);
        cfg(16'h9801);
        cfg(16'h9801);
        cfg(16'h9C01);
        cfg(16'h9C01);
        #1 chk("no ack after 4th word", int'(if1.tx_cfg_word), 'h0001);
        cfg(16'h9C01);
        #1 chk("ack after 5th word", int'(if1.tx_cfg_word), 'h4001);
        repeat (MC) cfg(16'hDC01);
        cycles(LT + 2);
        repeat (MC) idle_ev();
        cycles(LT + 2);
        #1;
        chk("interrupted config_reg", int'(creg1), 'hDC01);
        chk("interrupted speed", int'(spd1), 2);
        chk("interrupted duplex", int'(dup1), 1);

        // rx_sync low during ACK_DETECT
        restart_an = 1'b1;
        @(negedge clk);
        restart_an = 1'b0;
        cycles(LT + 2);
        repeat (MC) cfg(16'h9801);
        cfg(16'hD801);
        rx_sync = 1'b0;
        @(negedge clk);
        rx_sync = 1'b1;
        @(negedge clk);
        check_restarted("sync drop in ack");
        cfg(16'hD801);
        cfg(16'hD801);
        repeat (MC) idle_ev();
        cycles(40);
        #1 chk("no link without renegotiation", int'(cmp1), 0);
        negotiate(16'h9801);
        #1 chk("renegotiate 3", int'(cmp1), 1);

        // 1000BASE-X resolution from bit 5
        restart_an = 1'b1;
        @(negedge clk);
        restart_an = 1'b0;
        negotiate(16'h0020);
        #1;
        chk("basex complete", int'(cmp0), 1);
        chk("basex config_reg", int'(creg0), 'h4020);
        chk("basex speed", int'(spd0), 2);
        chk("basex duplex", int'(dup0), 1);
        chk("sgmii speed for 0020", int'(spd1), 0);
        chk("sgmii duplex for 0020", int'(dup1), 0);

        // bypass
        @(negedge clk);
        #2 rst_n = 1'b0;
        an_enable = 1'b0;
        cycles(2);
        #2 rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("bypass complete", int'(cmp1), 1);
        chk("bypass tx_cfg_en", int'(if1.tx_cfg_en), 0);
        chk("bypass speed", int'(spd1), 2);
        chk("bypass duplex", int'(dup1), 1);
        chk("bypass config_reg", int'(creg1), 0);
        chk("bypass basex complete", int'(cmp0), 1);
        cycles(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
